// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC generation, 1-cycle BRAM fetch, 2-entry
// instruction FIFO with valid/ready output and redirect flush.
module ifetch_unit #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    output logic [XLEN-1:0] icache_addr_o,
    output logic            icache_read_en_o,
    input  logic [XLEN-1:0] icache_read_data_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned OCC_W = 3;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  data0_q, data0_d, data1_q, data1_d;
    logic [XLEN-1:0]  epc0_q, epc0_d, epc1_q, epc1_d;

    logic             pop;
    logic             issue;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] wr_idx;

    assign instr_valid_o    = (count_q != '0);
    assign instr_o          = data0_q;
    assign instr_pc_o       = epc0_q;
    assign icache_addr_o    = pc_q;
    // Reset gating keeps the memory idle while the block is held in reset.
    assign icache_read_en_o = issue & rst_n_i;

    // Next-state: redirect flush, FIFO shift/push, fetch issue.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        data0_d       = data0_q;
        data1_d       = data1_q;
        epc0_d        = epc0_q;
        epc1_d        = epc1_q;

        pop       = instr_valid_o & instr_ready_i;
        occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
        issue     = !redirect_valid_i && (occupancy < OCC_W'(2));
        wr_idx    = count_q - CNT_W'(pop);

        if (redirect_valid_i) begin
            count_d = '0;
            pc_d    = redirect_pc_i & ~XLEN'(3);
        end else begin
            // Shift first so a same-cycle push lands behind the new head.
            if (pop) begin
                data0_d = data1_q;
                epc0_d  = epc1_q;
            end
            if (inflight_q) begin
                if (wr_idx == '0) begin
                    data0_d = icache_read_data_i;
                    epc0_d  = inflight_pc_q;
                end else begin
                    data1_d = icache_read_data_i;
                    epc1_d  = inflight_pc_q;
                end
            end
            count_d = count_q + CNT_W'(inflight_q) - CNT_W'(pop);
            if (issue) begin
                pc_d          = pc_q + XLEN'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            data0_q       <= '0;
            data1_q       <= '0;
            epc0_q        <= '0;
            epc1_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
            epc0_q        <= epc0_d;
            epc1_q        <= epc1_d;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: transaction-queue reference model plus directed scenarios.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic [31:0] icache_addr;
    logic        icache_rd_en;
    logic [31:0] icache_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    ifetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .icache_addr_o      (icache_addr),
        .icache_read_en_o   (icache_rd_en),
        .icache_read_data_i (icache_rdata),
        .redirect_valid_i   (redirect_valid),
        .redirect_pc_i      (redirect_pc),
        .instr_valid_o      (instr_valid),
        .instr_ready_i      (instr_ready),
        .instr_o            (instr),
        .instr_pc_o         (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mem[i] = i (word index)
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    // Synchronous BRAM, one-cycle latency, no read enable.
    always @(posedge clk) icache_rdata <= mem_word(icache_addr);

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } fetch_t;

    fetch_t      q[$];     // issued and not yet consumed, oldest first
    logic [31:0] dlv[$];   // PCs the DUT actually handed over
    logic [31:0] mpc;
    int          cyc;
    int          vec;
    int          errs;
    int          issues_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, compare, advance model, wait for next negedge.
    task automatic step(input logic rdr, input logic [31:0] rpc, input logic rdy);
        logic ev;
        logic pop;
        logic iss;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        #1;
        ev = (q.size() > 0) && (cyc >= q[0].cyc + 2);
        check("valid", 32'(instr_valid), 32'(ev));
        if (ev) begin
            check("head_pc", instr_pc, q[0].pc);
            check("head_instr", instr, mem_word(q[0].pc));
        end
        pop = ev && rdy;
        iss = !rdr && ((q.size() - int'(pop)) < 2);
        check("rd_en", 32'(icache_rd_en), 32'(iss));
        check("addr", icache_addr, mpc);
        if (icache_rd_en) issues_seen++;
        if (instr_valid && rdy && !rdr) dlv.push_back(instr_pc);
        if (rdr) begin
            q.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(q.pop_front());
            if (iss) begin
                q.push_back('{pc: mpc, cyc: cyc});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_rd_en", 32'(icache_rd_en), 32'd0);
        check("rst_addr", icache_addr, RST_PC);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        dlv.delete();
        mpc = RST_PC;
        cyc = 0;
    endtask

    initial begin
        vec = 0; errs = 0; cyc = 0; issues_seen = 0;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_rd_en", 32'(icache_rd_en), 32'd0);
        check("rst_addr", icache_addr, RST_PC);
        @(negedge clk);
        rst_n = 1'b1;
        mpc = RST_PC;

        // Streaming after reset with ready held high.
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        check("t1_count", 32'(dlv.size()), 32'd6);
        for (int i = 0; i < dlv.size(); i++)
            check("t1_seq", dlv[i], RST_PC + 32'(4 * i));

        // Back-pressure right after reset.
        do_reset();
        issues_seen = 0;
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
        check("t2_issues", 32'(issues_seen), 32'd2);
        check("t2_head", instr_pc, RST_PC);
        dlv.delete();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        check("t2_count", 32'(dlv.size()), 32'd3);
        for (int i = 0; i < dlv.size(); i++)
            check("t2_seq", dlv[i], RST_PC + 32'(4 * i));

        // Redirect with the pipe loaded.
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, 32'h0000_0203, 1'b0);
        dlv.delete();
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        check("t3_has", 32'(dlv.size() > 0), 32'd1);
        if (dlv.size() > 0) check("t3_first", dlv[0], 32'h0000_0200);

        // Redirect coinciding with a pop.
        for (int i = 0; i < 10 && !instr_valid; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h0000_0400, 1'b1);
        dlv.delete();
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        check("t4_has", 32'(dlv.size() > 0), 32'd1);
        if (dlv.size() > 0) check("t4_first", dlv[0], 32'h0000_0400);

        // Address wrap.
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        dlv.delete();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        check("t5_count", 32'(dlv.size() >= 4), 32'd1);
        if (dlv.size() >= 4) begin
            check("t5_0", dlv[0], 32'hFFFF_FFF8);
            check("t5_1", dlv[1], 32'hFFFF_FFFC);
            check("t5_2", dlv[2], 32'h0000_0000);
            check("t5_3", dlv[3], 32'h0000_0004);
        end

        // Mid-stream async reset, then restart latency.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        check("t6_count", 32'(dlv.size()), 32'd1);
        if (dlv.size() > 0) check("t6_first", dlv[0], RST_PC);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic        rd;
            logic [31:0] p;
            r  = ($urandom_range(0, 11) == 0);
            rd = ($urandom_range(0, 9) < 7);
            p  = $urandom;
            step(r, p, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
